// File: rtl/cipher_frame_assembler.sv
// ---------------------------------------------------------------------------
// cipher_frame_assembler
//
// Collects a byte-serial ciphertext stream into a MSG_LEN-byte frame for the
// decryptor. A frame closes on in_last or when the buffer fills. A closed
// frame is held stable, and the input is back-pressured, until the consumer
// accepts it. Buffer positions that the stream did not write read PAD_BYTE.
//
// Ports:
//   clk, rst     : single clock; synchronous active-high reset
//   in_byte      : ciphertext byte
//   in_valid     : in_byte is valid
//   in_last      : in_byte is the final byte of a message
//   in_ready     : a byte is accepted this cycle when in_valid is also high
//   frame_out    : assembled frame; index 0 holds the first byte received
//   frame_valid  : frame_out, frame_len and the flags are valid
//   frame_ready  : consumer accepts the held frame
//   frame_len    : number of stream bytes in the frame (1..MSG_LEN)
//   frame_short  : frame closed by in_last before MSG_LEN bytes
//   frame_trunc  : frame closed by count; the message continues in the next frame
// ---------------------------------------------------------------------------
module cipher_frame_assembler #(
  parameter int          MSG_LEN  = 22,
  parameter logic [7:0]  PAD_BYTE = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [7:0]                   frame_out [0:MSG_LEN-1],
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [$clog2(MSG_LEN+1)-1:0] frame_len,
  output logic                         frame_short,
  output logic                         frame_trunc
);

  localparam int LEN_W = $clog2(MSG_LEN + 1);
  localparam int IDX_W = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        fbuf_q [0:MSG_LEN-1];
  logic [7:0]        fbuf_d [0:MSG_LEN-1];
  logic [LEN_W-1:0]  len_q, len_d;
  logic              short_q, short_d;
  logic              trunc_q, trunc_d;
  logic              accept;

  // in_ready depends only on registered state and rst, never on frame_ready,
  // so there is always one idle cycle between frames.
  assign in_ready = !rst && (state_q == FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fbuf_d  = fbuf_q;
    len_d   = len_q;
    short_d = short_q;
    trunc_d = trunc_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          fbuf_d[idx_q] = in_byte;
          if (in_last || (idx_q == LAST_IDX)) begin
            state_d = HOLD;
            len_d   = LEN_W'(idx_q) + LEN_W'(1);
            // A last byte landing exactly on the final slot is neither short nor truncated.
            short_d = in_last && (idx_q < LAST_IDX);
            trunc_d = !in_last && (idx_q == LAST_IDX);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_d = FILL;
          idx_d   = '0;
          len_d   = '0;
          short_d = 1'b0;
          trunc_d = 1'b0;
          // Re-pad the whole buffer so the next frame's unwritten tail reads PAD_BYTE.
          for (int k = 0; k < MSG_LEN; k++) begin
            fbuf_d[k] = PAD_BYTE;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      len_q   <= '0;
      short_q <= 1'b0;
      trunc_q <= 1'b0;
      for (int k = 0; k < MSG_LEN; k++) begin
        fbuf_q[k] <= PAD_BYTE;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      short_q <= short_d;
      trunc_q <= trunc_d;
      fbuf_q  <= fbuf_d;
    end
  end

  assign frame_out   = fbuf_q;
  assign frame_valid = (state_q == HOLD);
  assign frame_len   = len_q;
  assign frame_short = short_q;
  assign frame_trunc = trunc_q;

endmodule

// File: tb/tb_cipher_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_cipher_frame_assembler
//
// Scoreboard bench: the driver feeds bytes and, on each accepted byte, a
// message-level model (a queue of pending bytes) pushes the expected frame
// when it closes. A monitor pops and compares on every frame handshake.
// Directed phases cover reset, latency, hold stability, truncation and
// mid-frame reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_cipher_frame_assembler;

  localparam int         MSG_LEN = 22;
  localparam int         LEN_W   = $clog2(MSG_LEN + 1);
  localparam logic [7:0] PAD     = 8'h20;

  typedef struct packed {
    logic [MSG_LEN*8-1:0] data;
    logic [7:0]           len;
    logic                 sh;
    logic                 tr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_byte = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [7:0]       frame_out [0:MSG_LEN-1];
  logic             frame_valid;
  logic             frame_ready = 1'b0;
  logic [LEN_W-1:0] frame_len;
  logic             frame_short;
  logic             frame_trunc;

  cipher_frame_assembler #(.MSG_LEN(MSG_LEN), .PAD_BYTE(PAD)) dut (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_short(frame_short), .frame_trunc(frame_trunc)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         frames_seen = 0;
  int         frames_exp = 0;
  bit         auto_rdy = 1'b0;
  logic [7:0] cur [$];
  exp_t       sb [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [MSG_LEN*8-1:0] pack_out();
    logic [MSG_LEN*8-1:0] v;
    for (int i = 0; i < MSG_LEN; i++) v[(MSG_LEN-1-i)*8 +: 8] = frame_out[i];
    return v;
  endfunction

  // Message-level model: bytes accumulate until in_last or a full frame.
  task automatic model_accept(input logic [7:0] b, input bit last);
    exp_t e;
    cur.push_back(b);
    if (last || cur.size() == MSG_LEN) begin
      for (int i = 0; i < MSG_LEN; i++)
        e.data[(MSG_LEN-1-i)*8 +: 8] = (i < cur.size()) ? cur[i] : PAD;
      e.len = 8'(cur.size());
      e.sh  = last && (cur.size() < MSG_LEN);
      e.tr  = !last && (cur.size() == MSG_LEN);
      sb.push_back(e);
      frames_exp++;
      cur.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    bit rdy;
    int waited = 0;
    in_byte = b; in_valid = 1'b1; in_last = last;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 300) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    if (rdy) model_accept(b, last);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    cur.delete();
    frames_exp -= sb.size();
    sb.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((frame_valid || sb.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Random consumer back-pressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (auto_rdy) frame_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare on every frame handshake.
  initial forever begin
    @(negedge clk);
    if (!rst && frame_valid && frame_ready) begin
      frames_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_data",  pack_out(), e.data);
        chk("frame_len",   frame_len, e.len);
        chk("frame_short", frame_short, e.sh);
        chk("frame_trunc", frame_trunc, e.tr);
      end
    end
  end

  logic [7:0] vec [22] = '{44,46,86,63,57,98,44,35,97,43,66,68,75,46,97,75,34,77,74,66,68,56};
  logic [MSG_LEN*8-1:0] pad_all, snap;

  initial begin
    for (int i = 0; i < MSG_LEN; i++) pad_all[i*8 +: 8] = PAD;

    // Reset state
    do_reset(3);
    @(negedge clk);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_frame_out", pack_out(), pad_all);
    chk("rst_flags", {frame_short, frame_trunc}, 0);
    @(posedge clk); #1;

    // Full 22-byte frame back-to-back; valid one cycle after closing byte
    auto_rdy = 1'b1;
    for (int i = 0; i < 22; i++) send(vec[i], i == 21);
    @(negedge clk);
    chk("latency_valid", frame_valid, 1);
    @(posedge clk); #1;

    // Short frame
    send(8'h48, 0);
    send(8'h49, 1);
    wait_idle();

    // Hold stability under back-pressure
    auto_rdy = 1'b0; frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), i == 3);
    in_byte = 8'h11; in_valid = 1'b1; in_last = 1'b0;
    @(negedge clk);
    snap = pack_out();
    chk("hold_valid", frame_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", pack_out(), snap);
    end
    @(posedge clk); #1 frame_ready = 1'b1;
    @(posedge clk); #1 frame_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", frame_valid, 0);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(8'h11, 0);
    @(negedge clk);
    chk("first_after_release", frame_out[0], 8'h11);
    @(posedge clk); #1;
    auto_rdy = 1'b1;
    send(8'h12, 1);
    wait_idle();

    // 25-byte message: truncated frame then short remainder
    for (int i = 0; i < 25; i++) send(8'($urandom), i == 24);
    wait_idle();

    // Reset mid-frame discards partial bytes
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), 0);
    do_reset(1);
    send(8'hA1, 0);
    send(8'hA2, 1);
    wait_idle();

    // Randomized traffic with gaps and stray in_last
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_last = 1'($urandom_range(0, 1));
        @(posedge clk); #1 in_last = 1'b0;
      end
      send(8'($urandom), $urandom_range(0, 7) == 0);
    end
    wait_idle();

    // Reset while a frame is held
    auto_rdy = 1'b0; frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), i == 2);
    @(negedge clk);
    chk("hold2_valid", frame_valid, 1);
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    chk("rst_hold_valid", frame_valid, 0);
    chk("rst_hold_ready", in_ready, 1);
    @(posedge clk); #1;
    auto_rdy = 1'b1;
    send(8'h5A, 1);
    wait_idle();
    chk("frame_count", frames_seen, frames_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
